guess_checker: RTL and testbench
================================

# guess_checker

Consumes the `word`/`mask` pair for the current level, accepts one guessed letter at a time through a valid/ready handshake, and tracks revealed slots, used letters and wrong guesses. It reports the round outcome through `lost_game` and `won_game`. `lost_game` feeds back to the level sequencer, which samples it on `start_game`. It sits between the keyboard/guess input path and the level sequencer; the display logic reads its outputs.

## Interface
- `MAX_WRONG`, default 6: misses that end the round; legal range 1..7.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start_game`  in  1  one-cycle pulse. Begins or restarts a round; same pulse as seen by the level sequencer.
- `word`  in  30  six 5-bit letter slots. Slot 0 = `word[29:25]` … slot 5 = `word[4:0]`. Letter code 1..26 = a..z; code 0 = blank slot.
- `mask`  in  26  bit i covers letter code i+1. 0 = letter present in word; 1 = absent.
- `guess_valid`  in  1  guess offered.
- `guess_letter`  in  5  guessed letter code.
- `guess_ready`  out  1  high only in WAIT.
- `result_valid`  out  1  one-cycle pulse per accepted guess.
- `result`  out  2  00 HIT, 01 MISS, 10 REPEAT, 11 INVALID; holds the last value.
- `revealed`  out  6  bit 5 = slot 0 … bit 0 = slot 5.
- `used_letters`  out  26  bit i set once letter code i+1 has been guessed.
- `wrong_count`  out  3  misses this round.
- `won_game`, `lost_game`  out  1  level flags.
- `mask_error`  out  1  sticky per round: `mask` disagreed with the slot compare.
- `state`  out  3  FSM state for debug.

## Operation
- States: IDLE, LOAD, WAIT, CHECK, WON, LOST.
- IDLE: entered on reset. `start_game` → LOAD.
- LOAD (one cycle): the exiting edge latches `word`/`mask` into internal registers and clears `used_letters`, `wrong_count`, `mask_error`, `won_game`, `lost_game`. Blank slots (code 0) load as already revealed; the rest load unrevealed. → WAIT.
- WAIT: handshake fires when `guess_valid` and `guess_ready` are both high. It captures `guess_letter` → CHECK. `guess_valid` without ready is ignored and must not be queued.
- CHECK (one cycle), with hit vector = latched slots equal to the letter:
  - code 0 or >26 → INVALID; no state change.
  - letter already in `used_letters` → REPEAT; no penalty.
  - otherwise set the used bit. Hit vector nonzero → HIT, `revealed |= hit`. Hit vector zero → MISS, `wrong_count+1`.
  - hit/miss is decided by the slot compare only. If `mask[code-1]` disagrees, set `mask_error`.
- After CHECK: all six revealed → WON; else `wrong_count == MAX_WRONG` → LOST; else WAIT. A MISS never causes WON.
- WON/LOST: flag high, `guess_ready` low, until `start_game` (→ LOAD) or reset.
- `start_game` in WAIT or CHECK aborts the round → LOAD. An in-flight CHECK is discarded: no `result_valid` and no counter update.
- Priority: reset > `start_game` > guess handshake.

## Timing
- Reset values: `state` IDLE; every output 0, including `revealed`, `result` and flags.
- Guess latency: handshake edge → CHECK. The CHECK exit edge updates `result`, `revealed`, `used_letters`, `wrong_count`, win/loss flags and `state` together. `result_valid` is high the cycle after CHECK.
- Guess throughput: one guess per 2 cycles. `guess_ready` is low during CHECK.
- `lost_game` stays high at the edge that samples `start_game` and falls the cycle after, in LOAD. This guarantees the sequencer sees it.
- `word`/`mask` are sampled only at the LOAD exit edge, one cycle after `start_game`, once the sequencer's level has updated. Input changes at any other time are ignored.
- `wrong_count` saturates at `MAX_WRONG`; it cannot wrap.

## Structure
- `hangman_pkg` holds letter width (5), slot count (6), state encodings, result codes and the `MAX_WRONG` default. The level sequencer shares the letter encoding from this package.
- One sub-module, `hangman_letter_match`: combinational compare of 6 slots against a letter → 6-bit hit vector, plus the mask consistency bit.

## Test plan
Test word: slots e,n,c,e,l,s = 5,14,3,5,12,19, with `mask` = 26'h3FBD7EB.
- Reset for 2 cycles → all outputs 0, `state`=IDLE, `guess_ready`=0.
- `start_game`, then guess 5 → after 3 cycles `result_valid`=1, HIT, `revealed`=6'b100100, `used_letters`[4]=1, `wrong_count`=0.
- Guess 5 again → REPEAT with no changes. Guess 0, then 27 → INVALID both times, `used_letters` unchanged.
- Guess 14,3,12,19 → last result HIT, `revealed`=6'b111111, `won_game`=1, `guess_ready`=0.
- New round; guess 1,2,4,6,7,8 → `wrong_count`=6, `lost_game`=1. Pulse `start_game` → `lost_game` still 1 at that edge, 0 next cycle; `revealed` cleared after LOAD.
- Clear mask bit 0 ('a' marked present), guess 1 → MISS, `mask_error`=1. Then `start_game` asserted during CHECK → no `result_valid`, `state`=LOAD next cycle.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared letter encoding, FSM state and result codes for the hangman guess path.
// Also used by the level sequencer.
package hangman_pkg;

    localparam int unsigned LETTER_W          = 5;
    localparam int unsigned SLOT_N            = 6;
    localparam int unsigned WORD_W            = LETTER_W * SLOT_N;
    localparam int unsigned ALPHA_N           = 26;
    localparam int unsigned RESULT_W          = 2;
    localparam int unsigned STATE_W           = 3;
    localparam int unsigned WRONG_W           = 3;
    localparam int unsigned MAX_WRONG_DEFAULT = 6;

    typedef logic [LETTER_W-1:0] letter_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WON   = 3'd4,
        ST_LOST  = 3'd5
    } state_t;

    typedef enum logic [RESULT_W-1:0] {
        RES_HIT     = 2'b00,
        RES_MISS    = 2'b01,
        RES_REPEAT  = 2'b10,
        RES_INVALID = 2'b11
    } result_t;

    // Codes 1..26 are letters; 0 is a blank slot, 27..31 are unused.
    function automatic logic letter_is_valid(input letter_t l);
        return (l != '0) && (l <= LETTER_W'(ALPHA_N));
    endfunction

    // Bit i set when l is letter code i+1; all zero for non-letters.
    function automatic logic [ALPHA_N-1:0] letter_onehot(input letter_t l);
        logic [ALPHA_N-1:0] oh;
        oh = '0;
        for (int i = 0; i < int'(ALPHA_N); i++) begin
            oh[i] = (l == LETTER_W'(i + 1));
        end
        return oh;
    endfunction

endpackage

// File: rtl/guess_checker_if.sv
// Guess handshake and per-guess result bus between the keyboard path and guess_checker.
interface guess_checker_if;
    import hangman_pkg::*;

    logic                guess_valid;
    logic [LETTER_W-1:0] guess_letter;
    logic                guess_ready;
    logic                result_valid;
    logic [RESULT_W-1:0] result;

    modport master (
        output guess_valid,
        output guess_letter,
        input  guess_ready,
        input  result_valid,
        input  result
    );

    modport slave (
        input  guess_valid,
        input  guess_letter,
        output guess_ready,
        output result_valid,
        output result
    );
endinterface

// File: rtl/hangman_letter_match.sv
// Combinational compare of all word slots against one letter, plus a check that
// the level's presence mask agrees with the slot compare.
module hangman_letter_match
    import hangman_pkg::*;
(
    input  logic [WORD_W-1:0]  word,
    input  logic [ALPHA_N-1:0] mask,
    input  letter_t            letter,
    output logic [SLOT_N-1:0]  hit,
    output logic               mask_mismatch
);

    // hit[k] covers word[5k +: 5], so bit 5 is slot 0 and bit 0 is slot 5.
    always_comb begin
        hit = '0;
        for (int k = 0; k < int'(SLOT_N); k++) begin
            hit[k] = (word[k*LETTER_W +: LETTER_W] == letter);
        end
    end

    // A mask bit of 1 claims the letter is absent, so agreement means it differs from |hit.
    assign mask_mismatch = letter_is_valid(letter)
                         && ((|(mask & letter_onehot(letter))) == (|hit));

endmodule

// File: rtl/guess_checker.sv
// Per-round hangman guess checker: latches the level word, scores one guess at a
// time and reports revealed slots, used letters, misses and the round outcome.
module guess_checker
    import hangman_pkg::*;
#(
    parameter int unsigned MAX_WRONG = MAX_WRONG_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_game,
    input  logic [WORD_W-1:0]  word,
    input  logic [ALPHA_N-1:0] mask,
    guess_checker_if.slave     gif,
    output logic [SLOT_N-1:0]  revealed,
    output logic [ALPHA_N-1:0] used_letters,
    output logic [WRONG_W-1:0] wrong_count,
    output logic               won_game,
    output logic               lost_game,
    output logic               mask_error,
    output logic [STATE_W-1:0] state
);

    localparam logic [WRONG_W-1:0] WRONG_LIMIT = WRONG_W'(MAX_WRONG);

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [ALPHA_N-1:0] mask_q, mask_d;
    letter_t            letter_q, letter_d;
    logic [SLOT_N-1:0]  revealed_q, revealed_d;
    logic [ALPHA_N-1:0] used_q, used_d;
    logic [WRONG_W-1:0] wrong_q, wrong_d;
    logic               won_q, won_d;
    logic               lost_q, lost_d;
    logic               mask_err_q, mask_err_d;
    result_t            result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               ready_q, ready_d;

    logic [SLOT_N-1:0]  hit;
    logic               mask_mismatch;
    logic [SLOT_N-1:0]  blank_slots;
    logic [ALPHA_N-1:0] letter_oh;
    logic               letter_ok;
    logic               letter_used;

    hangman_letter_match u_match (
        .word          (word_q),
        .mask          (mask_q),
        .letter        (letter_q),
        .hit           (hit),
        .mask_mismatch (mask_mismatch)
    );

    // Blank slots of the incoming word start the round already revealed.
    always_comb begin
        blank_slots = '0;
        for (int k = 0; k < int'(SLOT_N); k++) begin
            blank_slots[k] = (word[k*LETTER_W +: LETTER_W] == '0);
        end
    end

    assign letter_oh   = letter_onehot(letter_q);
    assign letter_ok   = letter_is_valid(letter_q);
    assign letter_used = |(used_q & letter_oh);

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        mask_d         = mask_q;
        letter_d       = letter_q;
        revealed_d     = revealed_q;
        used_d         = used_q;
        wrong_d        = wrong_q;
        won_d          = won_q;
        lost_d         = lost_q;
        mask_err_d     = mask_err_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_game) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                word_d     = word;
                mask_d     = mask;
                revealed_d = blank_slots;
                used_d     = '0;
                wrong_d    = '0;
                won_d      = 1'b0;
                lost_d     = 1'b0;
                mask_err_d = 1'b0;
                state_d    = start_game ? ST_LOAD : ST_WAIT;
            end
            ST_WAIT: begin
                if (start_game) begin
                    state_d = ST_LOAD;
                end else if (gif.guess_valid) begin
                    letter_d = gif.guess_letter;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // A restart discards the guess being scored.
                if (start_game) begin
                    state_d = ST_LOAD;
                end else begin
                    result_valid_d = 1'b1;
                    state_d        = ST_WAIT;
                    if (!letter_ok) begin
                        result_d = RES_INVALID;
                    end else if (letter_used) begin
                        result_d = RES_REPEAT;
                    end else begin
                        used_d = used_q | letter_oh;
                        if (mask_mismatch) mask_err_d = 1'b1;
                        if (|hit) begin
                            result_d   = RES_HIT;
                            revealed_d = revealed_q | hit;
                        end else begin
                            result_d = RES_MISS;
                            if (wrong_q < WRONG_LIMIT) wrong_d = wrong_q + WRONG_W'(1);
                        end
                        if ((|hit) && (&revealed_d)) begin
                            won_d   = 1'b1;
                            state_d = ST_WON;
                        end else if (wrong_d == WRONG_LIMIT) begin
                            lost_d  = 1'b1;
                            state_d = ST_LOST;
                        end
                    end
                end
            end
            ST_WON, ST_LOST: begin
                if (start_game) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            word_q         <= '0;
            mask_q         <= '0;
            letter_q       <= '0;
            revealed_q     <= '0;
            used_q         <= '0;
            wrong_q        <= '0;
            won_q          <= 1'b0;
            lost_q         <= 1'b0;
            mask_err_q     <= 1'b0;
            result_q       <= RES_HIT;
            result_valid_q <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_q         <= word_d;
            mask_q         <= mask_d;
            letter_q       <= letter_d;
            revealed_q     <= revealed_d;
            used_q         <= used_d;
            wrong_q        <= wrong_d;
            won_q          <= won_d;
            lost_q         <= lost_d;
            mask_err_q     <= mask_err_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            ready_q        <= ready_d;
        end
    end

    assign gif.guess_ready  = ready_q;
    assign gif.result_valid = result_valid_q;
    assign gif.result       = result_q;
    assign revealed         = revealed_q;
    assign used_letters     = used_q;
    assign wrong_count      = wrong_q;
    assign won_game         = won_q;
    assign lost_game        = lost_q;
    assign mask_error       = mask_err_q;
    assign state            = state_q;

endmodule

// File: tb/tb_guess_checker.sv
// Bench for guess_checker: directed walk through a full round pair, then random
// traffic, all compared each cycle against a slot/letter-array model of the game.
module tb_guess_checker;
    import hangman_pkg::*;

    localparam int unsigned MAXW = 6;

    logic        clk;
    logic        reset;
    logic        start_game;
    logic [29:0] word;
    logic [25:0] mask;
    logic [5:0]  revealed;
    logic [25:0] used_letters;
    logic [2:0]  wrong_count;
    logic        won_game;
    logic        lost_game;
    logic        mask_error;
    logic [2:0]  state;

    guess_checker_if gif ();

    guess_checker #(.MAX_WRONG(MAXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_game   (start_game),
        .word         (word),
        .mask         (mask),
        .gif          (gif.slave),
        .revealed     (revealed),
        .used_letters (used_letters),
        .wrong_count  (wrong_count),
        .won_game     (won_game),
        .lost_game    (lost_game),
        .mask_error   (mask_error),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: the level as a list of slot codes plus per-letter flags.
    int     m_slot[6];
    bit     m_absent[27];
    bit     m_used[27];
    bit     m_rev[6];
    int     m_wrong;
    bit     m_won, m_lost, m_merr, m_rv;
    int     m_res;
    int     m_cur;
    state_t m_state;

    function automatic logic [5:0] exp_revealed();
        logic [5:0] r;
        for (int s = 0; s < 6; s++) r[5-s] = m_rev[s];
        return r;
    endfunction

    function automatic logic [25:0] exp_used();
        logic [25:0] u;
        for (int i = 0; i < 26; i++) u[i] = m_used[i+1];
        return u;
    endfunction

    task automatic model_score(input int g);
        int  nhits;
        bit  all;
        m_rv    = 1'b1;
        m_state = ST_WAIT;
        if (g < 1 || g > 26) begin
            m_res = 3;
        end else if (m_used[g]) begin
            m_res = 2;
        end else begin
            m_used[g] = 1'b1;
            nhits = 0;
            for (int s = 0; s < 6; s++) begin
                if (m_slot[s] == g) begin
                    m_rev[s] = 1'b1;
                    nhits++;
                end
            end
            if (m_absent[g] == (nhits > 0)) m_merr = 1'b1;
            if (nhits > 0) begin
                m_res = 0;
            end else begin
                m_res = 1;
                if (m_wrong < int'(MAXW)) m_wrong++;
            end
            all = 1'b1;
            for (int s = 0; s < 6; s++) all &= m_rev[s];
            if (nhits > 0 && all) begin
                m_won   = 1'b1;
                m_state = ST_WON;
            end else if (m_wrong == int'(MAXW)) begin
                m_lost  = 1'b1;
                m_state = ST_LOST;
            end
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_state = ST_IDLE;
            for (int s = 0; s < 6; s++) begin m_slot[s] = 0; m_rev[s] = 1'b0; end
            for (int i = 0; i < 27; i++) begin m_used[i] = 1'b0; m_absent[i] = 1'b0; end
            m_wrong = 0; m_won = 1'b0; m_lost = 1'b0; m_merr = 1'b0;
            m_res = 0; m_rv = 1'b0; m_cur = 0;
            return;
        end
        m_rv = 1'b0;
        case (m_state)
            ST_IDLE, ST_WON, ST_LOST: if (start_game) m_state = ST_LOAD;
            ST_LOAD: begin
                for (int s = 0; s < 6; s++) begin
                    m_slot[s] = int'(word[(5-s)*5 +: 5]);
                    m_rev[s]  = (m_slot[s] == 0);
                end
                for (int i = 1; i <= 26; i++) begin
                    m_used[i]   = 1'b0;
                    m_absent[i] = mask[i-1];
                end
                m_wrong = 0; m_won = 1'b0; m_lost = 1'b0; m_merr = 1'b0;
                m_state = start_game ? ST_LOAD : ST_WAIT;
            end
            ST_WAIT: begin
                if (start_game) m_state = ST_LOAD;
                else if (gif.guess_valid) begin
                    m_cur   = int'(gif.guess_letter);
                    m_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (start_game) m_state = ST_LOAD;
                else model_score(m_cur);
            end
            default: m_state = ST_IDLE;
        endcase
    endtask

    always @(posedge clk) model_step();

    // Every cycle: all outputs against the model, sampled mid-cycle.
    always @(negedge clk) begin
        check("state",        32'(state),            32'(m_state));
        check("guess_ready",  32'(gif.guess_ready),  32'(m_state == ST_WAIT));
        check("result_valid", 32'(gif.result_valid), 32'(m_rv));
        check("result",       32'(gif.result),       32'(m_res));
        check("revealed",     32'(revealed),         32'(exp_revealed()));
        check("used_letters", 32'(used_letters),     32'(exp_used()));
        check("wrong_count",  32'(wrong_count),      32'(m_wrong));
        check("won_game",     32'(won_game),         32'(m_won));
        check("lost_game",    32'(lost_game),        32'(m_lost));
        check("mask_error",   32'(mask_error),       32'(m_merr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
    endtask

    // Offer one guess once ready; returns in the cycle the result is presented.
    task automatic do_guess(input logic [4:0] g);
        int n;
        n = 0;
        while (!gif.guess_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(gif.guess_ready), 32'd1);
        gif.guess_valid  = 1'b1;
        gif.guess_letter = g;
        tick();
        gif.guess_valid = 1'b0;
        tick();
    endtask

    task automatic rand_word();
        int v;
        bit any;
        any  = 1'b0;
        mask = '1;
        for (int s = 0; s < 6; s++) begin
            v = int'($urandom_range(0, 8));
            if (s == 5 && !any && v == 0) v = int'($urandom_range(1, 8));
            if (v != 0) begin
                any = 1'b1;
                mask[v-1] = 1'b0;
            end
            word[(5-s)*5 +: 5] = 5'(v);
        end
        if ($urandom_range(0, 9) == 0) mask[$urandom_range(0, 25)] ^= 1'b1;
    endtask

    logic [5:0] model_rev_now;

    initial begin
        reset            = 1'b1;
        start_game       = 1'b0;
        word             = '0;
        mask             = '0;
        gif.guess_valid  = 1'b0;
        gif.guess_letter = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_state",    32'(state),            32'(ST_IDLE));
        check("rst_ready",    32'(gif.guess_ready),  32'd0);
        check("rst_rv",       32'(gif.result_valid), 32'd0);
        check("rst_result",   32'(gif.result),       32'd0);
        check("rst_revealed", 32'(revealed),         32'd0);
        check("rst_used",     32'(used_letters),     32'd0);
        check("rst_flags",    32'({won_game, lost_game, mask_error, wrong_count}), 32'd0);

        // Round 1: e n c e l s
        word = {5'd5, 5'd14, 5'd3, 5'd5, 5'd12, 5'd19};
        mask = 26'h3FBD7EB;
        do_start();
        do_guess(5'd5);
        check("g5_rv",       32'(gif.result_valid), 32'd1);
        check("g5_result",   32'(gif.result),       32'(RES_HIT));
        check("g5_revealed", 32'(revealed),         32'h24);
        check("g5_used4",    32'(used_letters[4]),  32'd1);
        check("g5_wrong",    32'(wrong_count),      32'd0);
        model_rev_now = exp_revealed();
        check("model_g5_revealed", 32'(model_rev_now), 32'h24);
        do_guess(5'd5);
        check("rep_result",   32'(gif.result),   32'(RES_REPEAT));
        check("rep_revealed", 32'(revealed),     32'h24);
        check("rep_used",     32'(used_letters), 32'h10);
        do_guess(5'd0);
        check("inv0_result",  32'(gif.result),   32'(RES_INVALID));
        do_guess(5'd27);
        check("inv27_result", 32'(gif.result),   32'(RES_INVALID));
        check("inv_used",     32'(used_letters), 32'h10);
        do_guess(5'd14);
        do_guess(5'd3);
        do_guess(5'd12);
        check("g12_result",   32'(gif.result),   32'(RES_HIT));
        do_guess(5'd19);
        check("win_result",   32'(gif.result),      32'(RES_HIT));
        check("win_revealed", 32'(revealed),        32'h3F);
        check("win_flag",     32'(won_game),        32'd1);
        check("win_ready",    32'(gif.guess_ready), 32'd0);
        check("win_state",    32'(state),           32'(ST_WON));

        // Round 2: six misses end the round
        do_start();
        do_guess(5'd1);
        check("miss_result", 32'(gif.result), 32'(RES_MISS));
        do_guess(5'd2);
        do_guess(5'd4);
        do_guess(5'd6);
        do_guess(5'd7);
        check("miss5_wrong", 32'(wrong_count), 32'd5);
        do_guess(5'd8);
        check("lose_wrong", 32'(wrong_count),  32'd6);
        check("lose_flag",  32'(lost_game),    32'd1);
        check("lose_state", 32'(state),        32'(ST_LOST));
        check("lose_used",  32'(used_letters), 32'hEB);
        check("lose_won",   32'(won_game),     32'd0);

        // Restart with 'a' wrongly marked present
        mask       = 26'h3FBD7EA;
        start_game = 1'b1;
        check("lost_before_edge", 32'(lost_game), 32'd1);
        tick();
        start_game = 1'b0;
        check("lost_in_load", 32'(lost_game), 32'd1);
        check("load_state",   32'(state),     32'(ST_LOAD));
        tick();
        check("lost_cleared",   32'(lost_game), 32'd0);
        check("revealed_clear", 32'(revealed),  32'd0);
        check("wait_state",     32'(state),     32'(ST_WAIT));
        do_guess(5'd1);
        check("merr_result", 32'(gif.result),  32'(RES_MISS));
        check("merr_flag",   32'(mask_error),  32'd1);
        check("merr_wrong",  32'(wrong_count), 32'd1);

        // Restart while a guess is being scored
        gif.guess_valid  = 1'b1;
        gif.guess_letter = 5'd2;
        tick();
        gif.guess_valid = 1'b0;
        check("abort_in_check", 32'(state), 32'(ST_CHECK));
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        check("abort_rv",    32'(gif.result_valid), 32'd0);
        check("abort_state", 32'(state),            32'(ST_LOAD));
        check("abort_wrong", 32'(wrong_count),      32'd1);
        check("abort_used",  32'(used_letters),     32'h1);
        tick();
        check("abort_reload_merr", 32'(mask_error),  32'd0);
        check("abort_reload_used", 32'(used_letters), 32'd0);

        // Random traffic against the model
        rand_word();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset = ($urandom_range(0, 799) == 0);
            if (m_state == ST_IDLE || m_state == ST_WON || m_state == ST_LOST)
                start_game = ($urandom_range(0, 3) == 0);
            else
                start_game = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) rand_word();
            gif.guess_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) < 7)
                gif.guess_letter = 5'($urandom_range(1, 8));
            else
                gif.guess_letter = 5'($urandom_range(0, 31));
            tick();
        end
        reset           = 1'b0;
        start_game      = 1'b0;
        gif.guess_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
